// File: rtl/rr_sched32_pkg.sv
// Shared types and constants for the 32-way round-robin scheduler.
package rr_sched32_pkg;

    localparam int NREQ = 32;
    localparam int IDXW = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_sched32_onehot_dec32.sv
// Combinational 5-to-32 one-hot decoder for the grant index.
module onehot_dec32
    import rr_sched32_pkg::*;
(
    input  logic [IDXW-1:0] idx,
    output logic [NREQ-1:0] onehot
);

    // Set exactly the bit selected by idx.
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_sched32.sv
// Round-robin scheduler: one downstream resource shared by 32 requesters.
//
// Handshake: gnt_valid rises with a registered offer and stays high, with
// gnt_idx/gnt_onehot stable, until gnt_ready is sampled high on a rising
// edge; the offer is never withdrawn. req/mask are only looked at in IDLE,
// gnt_ready only in OFFER, done only in HOLD.
module rr_sched32
    import rr_sched32_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    output logic            gnt_valid,
    input  logic            gnt_ready,
    output logic [IDXW-1:0] gnt_idx,
    output logic [NREQ-1:0] gnt_onehot,
    output logic            busy,
    input  logic            done,
    output logic            timeout_err,
    output state_t          dbg_state
);

    state_t          state, state_d;
    logic [IDXW-1:0] last, last_d;
    logic [IDXW-1:0] idx, idx_d;
    logic [TW-1:0]   cnt, cnt_d;
    logic            tmo_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] start;
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] k;
    logic [IDXW-1:0] found_idx;
    logic [NREQ-1:0] dec_onehot;

    assign elig      = req & mask;
    assign start     = last + IDXW'(1);
    assign gnt_idx   = idx;
    assign dbg_state = state;

    // Rotate so bit 0 is the requester just after last, pick the lowest set
    // bit, then add the rotation back (5-bit add wraps mod 32).
    always_comb begin
        rot  = '0;
        k    = '0;
        pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            k      = IDXW'(i) + start;
            rot[i] = elig[k];
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) pick = IDXW'(i);
        end
        found_idx = pick + start;
    end

    // Next-state and next-register logic for IDLE / OFFER / HOLD.
    always_comb begin
        state_d = state;
        last_d  = last;
        idx_d   = idx;
        cnt_d   = cnt;
        tmo_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|elig) begin
                    idx_d   = found_idx;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (gnt_ready) begin
                    last_d  = idx;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // done takes priority over a simultaneous timeout
                if (done) begin
                    state_d = ST_IDLE;
                end else if (cnt == TW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode the index that will be presented next cycle.
    onehot_dec32 u_dec (
        .idx    (idx_d),
        .onehot (dec_onehot)
    );

    // State and registered outputs; outputs follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last        <= '1;
            idx         <= '0;
            cnt         <= '0;
            gnt_valid   <= 1'b0;
            gnt_onehot  <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            last        <= last_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            gnt_valid   <= (state_d == ST_OFFER);
            gnt_onehot  <= (state_d == ST_IDLE) ? '0 : dec_onehot;
            busy        <= (state_d == ST_HOLD);
            timeout_err <= tmo_d;
        end
    end

endmodule

// File: tb/tb_rr_sched32.sv
// Self-checking bench for rr_sched32 with a grant-order scoreboard.
module tb_rr_sched32;
    import rr_sched32_pkg::*;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic [31:0] mask;
    logic        gnt_valid;
    logic        gnt_ready;
    logic [4:0]  gnt_idx;
    logic [31:0] gnt_onehot;
    logic        busy;
    logic        done;
    logic        timeout_err;
    state_t      dbg_state;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_last   = 31;

    rr_sched32 #(.TIMEOUT(TMO), .TW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mask        (mask),
        .gnt_valid   (gnt_valid),
        .gnt_ready   (gnt_ready),
        .gnt_idx     (gnt_idx),
        .gnt_onehot  (gnt_onehot),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference search: first eligible index after last, wrapping.
    function automatic int rr_model(input logic [31:0] e, input int last);
        int j;
        for (int s = 1; s <= 32; s++) begin
            j = (last + s) % 32;
            if (e[j]) return j;
        end
        return -1;
    endfunction

    // Scoreboard: every accepted offer is compared against the queue head.
    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] one;
        if (rst_n && gnt_valid && gnt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", {27'd0, gnt_idx}, 32'hFFFF_FFFF);
            end else begin
                e   = exp_q.pop_front();
                one = 32'd1;
                check("grant_idx", {27'd0, gnt_idx}, e);
                check("grant_onehot", gnt_onehot, one << e);
            end
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_last = 31;
    endtask

    // ddelay: 0 = done in first HOLD cycle, -1 = let it time out, -2 = leave held
    task automatic serve(input int rdelay, input int ddelay, input bit drop_req);
        int e;
        int n;
        e = rr_model(req & mask, m_last);
        if (e < 0) begin
            check("serve_nothing_eligible", 32'd0, 32'd1);
            return;
        end
        exp_q.push_back(32'(e));
        m_last = e;
        n = 0;
        @(negedge clk);
        while (!gnt_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!gnt_valid) begin
            check("wait_valid", {31'd0, gnt_valid}, 32'd1);
            return;
        end
        for (int i = 0; i < rdelay; i++) begin
            @(posedge clk);
            #1;
            if (drop_req && i == 0) req = 32'd0;
            @(negedge clk);
            check("offer_held_valid", {31'd0, gnt_valid}, 32'd1);
            check("offer_held_idx", {27'd0, gnt_idx}, 32'(e));
        end
        @(posedge clk);
        #1 gnt_ready = 1'b1;
        @(posedge clk);
        #1 gnt_ready = 1'b0;
        @(negedge clk);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_valid_low", {31'd0, gnt_valid}, 32'd0);
        if (ddelay == 0) begin
            done = 1'b1;
            @(posedge clk);
            #1 done = 1'b0;
            @(negedge clk);
            check("done_busy_low", {31'd0, busy}, 32'd0);
            check("idle_onehot_zero", gnt_onehot, 32'd0);
            check("done_no_timeout", {31'd0, timeout_err}, 32'd0);
        end else if (ddelay == -1) begin
            n = 1;
            @(negedge clk);
            while (busy && n < 50) begin
                n++;
                @(negedge clk);
            end
            check("timeout_busy_cycles", 32'(n), 32'(TMO));
            check("timeout_pulse", {31'd0, timeout_err}, 32'd1);
            @(negedge clk);
            check("timeout_pulse_end", {31'd0, timeout_err}, 32'd0);
        end
    endtask

    // stimulus
    initial begin
        req       = 32'd0;
        mask      = 32'd0;
        gnt_ready = 1'b0;
        done      = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_valid", {31'd0, gnt_valid}, 32'd0);
        check("rst_onehot", gnt_onehot, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tmo", {31'd0, timeout_err}, 32'd0);
        check("rst_idx", {27'd0, gnt_idx}, 32'd0);
        reset_dut();

        // single requester, one-cycle hold
        req  = 32'h0000_0001;
        mask = 32'hFFFF_FFFF;
        serve(0, 0, 1'b0);
        req = 32'd0;

        // wrap-around order 0, 4, 31, 0
        reset_dut();
        req = 32'h8000_0011;
        for (int i = 0; i < 4; i++) serve(0, 0, 1'b0);

        // mask limits grants to 8, then masks everything
        req  = 32'hFFFF_FFFF;
        mask = 32'h0000_0100;
        for (int i = 0; i < 3; i++) serve($urandom_range(0, 2), 0, 1'b0);
        mask = 32'd0;
        repeat (6) begin
            @(negedge clk);
            check("masked_idle", {31'd0, gnt_valid}, 32'd0);
        end

        // offer for 5 held while ready low and req[5] drops
        mask = 32'hFFFF_FFFF;
        req  = 32'h0000_0020;
        serve(3, 0, 1'b1);

        // timeout on 9, then 10 served normally
        req = 32'h0000_0600;
        serve(0, -1, 1'b0);
        serve(0, 0, 1'b0);
        req = 32'd0;

        // async reset while holding 12; pointer must restart from 0
        req = 32'h0000_1000;
        serve(0, -2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, gnt_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_onehot", gnt_onehot, 32'd0);
        check("arst_idx", {27'd0, gnt_idx}, 32'd0);
        check("arst_tmo", {31'd0, timeout_err}, 32'd0);
        req = 32'h0000_3000;
        @(negedge clk);
        rst_n  = 1'b1;
        m_last = 31;
        serve(0, 0, 1'b0);
        serve(0, 0, 1'b0);
        req = 32'd0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
